mips_debug_ctrl: RTL and testbench

Debug-side controller for the MIPS_DLX core. It accepts command bytes from a UART receiver and drives the core's `enable` input to run, halt or single-step the pipeline. When the core stops, it snapshots `debug_signal`, `zero` and an enabled-cycle counter. It then streams the snapshot as a byte frame to a UART transmitter. It sits between the UART byte interfaces and the MIPS_DLX top level, and replaces the fixed `enable = 1` used in simulation.

---
 rtl/mips_debug_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mips_debug_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl: debug-side run/halt/step controller for the MIPS_DLX core.
// Decodes UART command bytes, drives the core enable, snapshots debug state
// when the core stops and streams it out as a byte frame.
// Optional feature macro: DEBUG_CYCLE_COUNT_EN
//   defined   -> 32-bit enabled-cycle counter, 7-byte frame
//                (hdr, count[31:0] MSB first, {zero,5'b0,dbg[9:8]}, dbg[7:0])
//   undefined -> no counter, 3-byte frame (hdr, {zero,5'b0,dbg[9:8]}, dbg[7:0])
module mips_debug_ctrl #(
  parameter logic [7:0] CMD_RUN   = 8'h63,
  parameter logic [7:0] CMD_STEP  = 8'h73,
  parameter logic [7:0] CMD_HALT  = 8'h68,
  parameter logic [7:0] FRAME_HDR = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [9:0] debug_signal,
  input  logic       zero,
  output logic       enable,
  output logic       halted,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam logic [2:0] ST_HALT = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_STEP = 3'd2;
  localparam logic [2:0] ST_SNAP = 3'd3;
  localparam logic [2:0] ST_SEND = 3'd4;

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 3;
`endif
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [2:0]             state_reg;
  logic [2:0]             state_next;
  logic                   enable_reg;
  logic                   halted_reg;
  logic                   tx_valid_reg;
  logic [7:0]             tx_data_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [IDX_W-1:0]       idx_next;
  logic                   tx_fire;
  logic                   last_fire;
  logic                   is_run;
  logic                   is_step;
  logic                   is_halt;
  logic [FRAME_LEN*8-1:0] snap_word;
  logic [7:0]             snap_bytes [FRAME_LEN];
  logic [7:0]             frame_reg  [FRAME_LEN];

  // Command decode; only meaningful on a receive strobe.
  assign is_run  = rx_valid && (rx_data == CMD_RUN);
  assign is_step = rx_valid && (rx_data == CMD_STEP);
  assign is_halt = rx_valid && (rx_data == CMD_HALT);

  assign tx_fire   = tx_valid_reg && tx_ready;
  assign last_fire = tx_fire && (idx_reg == LAST_IDX);
  assign idx_next  = idx_reg + IDX_W'(1);

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] count_reg;

  // Enabled-cycle counter: counts every cycle the core is enabled, wraps
  // naturally, and is only cleared by reset (never by a frame dump).
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= 32'd0;
    end else if (enable_reg) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign snap_word = {FRAME_HDR, count_reg, zero, 5'b0, debug_signal};
`else
  assign snap_word = {FRAME_HDR, zero, 5'b0, debug_signal};
`endif

  // Split the snapshot word into frame bytes, first byte in the MSBs.
  genvar gi;
  generate
    for (gi = 0; gi < FRAME_LEN; gi++) begin : g_snap_bytes
      assign snap_bytes[gi] = snap_word[8*(FRAME_LEN-1-gi) +: 8];
    end
  endgenerate

  // Next-state logic; commands are only looked at in HALT and RUN, so any
  // strobe arriving during STEP, SNAP or SEND is silently dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HALT: begin
        if (is_run) begin
          state_next = ST_RUN;
        end else if (is_step) begin
          state_next = ST_STEP;
        end else if (is_halt) begin
          state_next = ST_SNAP;
        end
      end
      ST_RUN: begin
        if (is_halt) begin
          state_next = ST_SNAP;
        end
      end
      ST_STEP: state_next = ST_SNAP;
      ST_SNAP: state_next = ST_SEND;
      ST_SEND: begin
        if (last_fire) begin
          state_next = ST_HALT;
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  // State register plus registered enable/halted decoded from the next state,
  // so both outputs come straight from flops and line up with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= ST_HALT;
      enable_reg <= 1'b0;
      halted_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      enable_reg <= (state_next == ST_RUN) || (state_next == ST_STEP);
      halted_reg <= (state_next == ST_HALT);
    end
  end

  // Frame capture: the whole snapshot is frozen in SNAP so later core
  // activity cannot corrupt a frame that is still being sent.
  always_ff @(posedge clock) begin
    if (state_reg == ST_SNAP) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        frame_reg[i] <= snap_bytes[i];
      end
    end
  end

  // Transmit side: byte 0 is loaded straight from the snapshot so tx_valid
  // rises the cycle after SNAP; tx_data only moves on an accepted transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      idx_reg      <= '0;
    end else if (state_reg == ST_SNAP) begin
      tx_valid_reg <= 1'b1;
      tx_data_reg  <= snap_bytes[0];
      idx_reg      <= '0;
    end else if (tx_fire) begin
      if (idx_reg == LAST_IDX) begin
        tx_valid_reg <= 1'b0;
        idx_reg      <= '0;
      end else begin
        tx_data_reg <= frame_reg[idx_next];
        idx_reg     <= idx_next;
      end
    end
  end

  assign enable   = enable_reg;
  assign halted   = halted_reg;
  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb_mips_debug_ctrl: scoreboard bench for mips_debug_ctrl. The command
// driver keeps a mode/count model and queues the expected frame bytes;
// a negedge monitor compares every offered byte against the queue head.
module tb_mips_debug_ctrl;

  localparam logic [7:0] CMD_RUN   = 8'h63;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_HALT  = 8'h68;
  localparam logic [7:0] FRAME_HDR = 8'hA5;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 3;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [9:0] debug_signal = 10'h000;
  logic       zero = 1'b0;
  logic       enable;
  logic       halted;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;

  mips_debug_ctrl dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .debug_signal(debug_signal), .zero(zero), .enable(enable), .halted(halted),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_strobe = 0;
  logic [7:0] exp_q [$];
  // model: 0 = halted, 1 = running, 2 = snapshot/frame in flight
  int m_mode = 0;
  logic [31:0] m_count = 32'd0;
  int run_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Inputs are driven 2 time units after the rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
    cyc++;
  endtask

  task automatic push_frame();
    exp_q.push_back(FRAME_HDR);
`ifdef DEBUG_CYCLE_COUNT_EN
    exp_q.push_back(m_count[31:24]);
    exp_q.push_back(m_count[23:16]);
    exp_q.push_back(m_count[15:8]);
    exp_q.push_back(m_count[7:0]);
`endif
    exp_q.push_back({zero, 5'b0, debug_signal[9:8]});
    exp_q.push_back(debug_signal[7:0]);
  endtask

  // One-cycle command strobe, applied to the reference model at the same time.
  task automatic send_cmd(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    last_strobe = cyc;
    case (m_mode)
      0: begin
        if (b == CMD_RUN) begin
          m_mode = 1;
          run_start = cyc;
        end else if (b == CMD_STEP) begin
          m_count = m_count + 32'd1;
          push_frame();
          m_mode = 2;
        end else if (b == CMD_HALT) begin
          push_frame();
          m_mode = 2;
        end
      end
      1: begin
        if (b == CMD_HALT) begin
          m_count = m_count + 32'(cyc - run_start);
          push_frame();
          m_mode = 2;
        end
      end
      default: ;
    endcase
    $display("cmd %02h at cycle %0d model mode %0d count %0d", b, cyc, m_mode, m_count);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    exp_q.delete();
    m_count = 32'd0;
    m_mode = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready pattern 1,0,0,1
  task automatic wait_frame_done(input int mode);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    n = 0;
    while (!(halted && !tx_valid && exp_q.size() == 0) && n < 300) begin
      case (mode)
        1:       tx_ready = 1'($urandom_range(0, 1));
        2:       tx_ready = pat[n % 4];
        default: tx_ready = 1'b1;
      endcase
      tick();
      n++;
    end
    tx_ready = 1'b1;
    chk("frame_done_in_time", 32'(n < 300), 32'd1);
    chk("halted_after_frame", 32'(halted), 32'd1);
    m_mode = 0;
  endtask

  // Monitor: every offered byte must equal the queue head (this also proves
  // tx_data holds while stalled); the head is consumed only on a transfer.
  always @(negedge clock) begin
    if (!reset && tx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got byte %02h expected none at cycle %0d", tx_data, cyc);
      end else begin
        chk("tx_byte", 32'(tx_data), 32'(exp_q[0]));
        if (tx_ready) begin
          $display("tx byte %02h accepted at cycle %0d", tx_data, cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    int k;

    // Reset values, then 5 idle cycles.
    tick();
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_enable", 32'(enable), 32'd0);
      chk("idle_halted", 32'(halted), 32'd1);
      chk("idle_tx_valid", 32'(tx_valid), 32'd0);
    end

    // Single step with a fixed snapshot.
    debug_signal = 10'h2B5;
    zero = 1'b1;
    send_cmd(CMD_STEP);
    chk("step_enable_n1", 32'(enable), 32'd1);
    tick();
    chk("step_enable_n2", 32'(enable), 32'd0);
    chk("step_tx_valid_n2", 32'(tx_valid), 32'd0);
    tick();
    chk("step_tx_valid_n3", 32'(tx_valid), 32'd1);
    wait_frame_done(0);

    // Run 100 cycles then halt, from a clean counter; also exact send timing.
    do_reset();
    debug_signal = 10'h0C3;
    zero = 1'b0;
    send_cmd(CMD_RUN);
    chk("run_enable", 32'(enable), 32'd1);
    repeat (100) tick();
    chk("run_enable_held", 32'(enable), 32'd1);
    send_cmd(CMD_HALT);
    m = last_strobe;
    chk("halt_enable_m1", 32'(enable), 32'd0);
    chk("halt_tx_valid_m1", 32'(tx_valid), 32'd0);
    tick();
    chk("halt_tx_valid_m2", 32'(tx_valid), 32'd1);
    k = 0;
    while (tx_valid && k < 50) begin
      tick();
      k++;
    end
    chk("send_end_cycle", 32'(cyc - m), 32'(FLEN + 2));
    wait_frame_done(0);

    // Backpressure on a re-dump from HALT.
    debug_signal = 10'h15A;
    zero = 1'b1;
    send_cmd(CMD_HALT);
    wait_frame_done(2);

    // Command drops.
    send_cmd(CMD_RUN);
    repeat (3) tick();
    send_cmd(CMD_RUN);
    chk("run_in_run_enable", 32'(enable), 32'd1);
    repeat (4) tick();
    send_cmd(CMD_HALT);
    wait_frame_done(0);
    send_cmd(8'h00);
    chk("junk_halted", 32'(halted), 32'd1);
    chk("junk_enable", 32'(enable), 32'd0);
    send_cmd(CMD_HALT);
    tick();
    tick();
    send_cmd(CMD_STEP);
    wait_frame_done(0);
    repeat (3) tick();
    chk("drop_step_enable", 32'(enable), 32'd0);
    chk("drop_step_halted", 32'(halted), 32'd1);

    // Strobe coinciding with the last transfer is dropped.
    send_cmd(CMD_HALT);
    m = last_strobe;
    while (cyc < m + FLEN + 1) tick();
    send_cmd(CMD_RUN);
    chk("last_xfer_tx_valid", 32'(tx_valid), 32'd0);
    chk("last_xfer_halted", 32'(halted), 32'd1);
    tick();
    chk("last_xfer_enable", 32'(enable), 32'd0);
    wait_frame_done(0);

    // Randomized command mix.
    for (int it = 0; it < 30; it++) begin
      logic [7:0] c;
      case ($urandom_range(0, 4))
        0:       c = CMD_RUN;
        1:       c = CMD_STEP;
        2, 3:    c = CMD_HALT;
        default: c = 8'($urandom_range(0, 255));
      endcase
      debug_signal = 10'($urandom_range(0, 1023));
      zero = 1'($urandom_range(0, 1));
      send_cmd(c);
      if (m_mode == 2) begin
        if ($urandom_range(0, 1) == 1) begin
          tick();
          send_cmd(($urandom_range(0, 1) == 1) ? CMD_RUN : CMD_STEP);
        end
        wait_frame_done(1);
      end else begin
        repeat ($urandom_range(0, 20)) tick();
      end
    end
    if (m_mode == 1) begin
      send_cmd(CMD_HALT);
      wait_frame_done(1);
    end

    // Reset on the 3rd frame byte abandons the frame and clears the count.
    send_cmd(CMD_RUN);
    repeat (10) tick();
    send_cmd(CMD_HALT);
    m = last_strobe;
    while (cyc < m + 4) tick();
    reset = 1'b1;
    exp_q.delete();
    m_count = 32'd0;
    m_mode = 0;
    tick();
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd1);
    chk("midrst_enable", 32'(enable), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    tick();
    debug_signal = 10'h3FF;
    zero = 1'b0;
    send_cmd(CMD_HALT);
    wait_frame_done(0);

    chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
